// File: rtl/riscv_defs.sv
// rtl/riscv_defs.sv - shared RV32 execute-stage types: ALU/M-extension opcodes, control bus, M-unit states
package riscv_defs;

    localparam int NB_WORD = 32;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SLL  = 3'd1,
        ALU_SLT  = 3'd2,
        ALU_SLTU = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SR   = 3'd5,
        ALU_OR   = 3'd6,
        ALU_AND  = 3'd7
    } alu_op_t;

    // Encoding mirrors funct3: bit 2 marks divide-class ops, bits 2:1 == 2'b11 the remainders
    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } md_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_t;

    typedef struct packed {
        logic    alu_src1;
        logic    alu_src2;
        alu_op_t alu_op;
        logic    arith_logic;
        logic    md_en;
        md_op_t  md_op;
    } control_bus_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - single-cycle integer ALU; arith_logic selects SUB on ADD and arithmetic shift on SR
module alu
    import riscv_defs::*;
#(
    parameter int NB_WORD = 32
) (
    input  logic [NB_WORD-1:0] a_i,
    input  logic [NB_WORD-1:0] b_i,
    input  alu_op_t            op_i,
    input  logic               arith_logic_i,
    output logic [NB_WORD-1:0] result_o
);
    localparam int NB_SH = $clog2(NB_WORD);

    logic [NB_SH-1:0] shamt;

    assign shamt = b_i[NB_SH-1:0];

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:  result_o = arith_logic_i ? (a_i - b_i) : (a_i + b_i);
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SLT:  result_o = {{(NB_WORD-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU: result_o = {{(NB_WORD-1){1'b0}}, (a_i < b_i)};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SR:   result_o = arith_logic_i ? $unsigned($signed(a_i) >>> shamt) : (a_i >> shamt);
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative RV32M unit: shift-add multiply and restoring divide, one bit per cycle
module md_unit
    import riscv_defs::*;
#(
    parameter int NB_WORD = 32,
    parameter int NB_CNT  = $clog2(NB_WORD) + 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               flush_i,
    input  md_op_t             op_i,
    input  logic [NB_WORD-1:0] a_i,
    input  logic [NB_WORD-1:0] b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [NB_WORD-1:0] result_o
);
    md_state_t            state_q, state_d;
    logic [NB_CNT-1:0]    cnt_q, cnt_d;
    logic [2*NB_WORD-1:0] acc_q, acc_d, acc_step, prod_fix;
    logic [NB_WORD-1:0]   dvs_q, dvs_d;
    md_op_t               op_q, op_d;
    logic                 neg_q, neg_d, bzero_q, bzero_d;
    logic                 last, is_div, is_rem;
    logic                 a_sgn, b_sgn, a_neg, b_neg;
    logic [NB_WORD-1:0]   a_mag, b_mag, quot, rem;
    logic [NB_WORD:0]     sum, r_shift, diff;
    logic                 ge;

    assign last   = (cnt_q == NB_CNT'(NB_WORD - 1));
    assign is_div = op_q[2];
    assign is_rem = op_q[2] & op_q[1];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            op_q    <= MUL;
            neg_q   <= 1'b0;
            bzero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            bzero_q <= bzero_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (flush_i || last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : fsm_outputs
        busy_o = (state_q == RUN);
        done_o = (state_q == RUN) && last && !flush_i;
    end

    // Signed operands become magnitudes; the sign is re-applied once at the end
    always_comb begin : operand_capture
        a_sgn = (op_i == MULH) || (op_i == MULHSU) || (op_i == DIV) || (op_i == REM);
        b_sgn = (op_i == MULH) || (op_i == DIV) || (op_i == REM);
        a_neg = a_sgn && a_i[NB_WORD-1];
        b_neg = b_sgn && b_i[NB_WORD-1];
        a_mag = a_neg ? -a_i : a_i;
        b_mag = b_neg ? -b_i : b_i;
    end

    // acc_q holds {product high, multiplier} for multiply and {remainder, dividend/quotient} for divide
    always_comb begin : datapath
        sum      = {1'b0, acc_q[2*NB_WORD-1:NB_WORD]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
        r_shift  = {acc_q[2*NB_WORD-1:NB_WORD], acc_q[NB_WORD-1]};
        ge       = (r_shift >= {1'b0, dvs_q});
        diff     = r_shift - {1'b0, dvs_q};
        acc_step = is_div ? {(ge ? diff[NB_WORD-1:0] : r_shift[NB_WORD-1:0]), acc_q[NB_WORD-2:0], ge}
                          : {sum, acc_q[NB_WORD-1:1]};
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        dvs_d    = dvs_q;
        op_d     = op_q;
        neg_d    = neg_q;
        bzero_d  = bzero_q;
        if (state_q == IDLE) begin
            if (start_i) begin
                acc_d   = {{NB_WORD{1'b0}}, a_mag};
                dvs_d   = b_mag;
                op_d    = op_i;
                cnt_d   = '0;
                neg_d   = (op_i == REM) ? a_neg : (a_neg ^ b_neg);
                bzero_d = (b_i == '0);
            end
        end else begin
            acc_d = acc_step;
            cnt_d = cnt_q + NB_CNT'(1);
        end
    end

    // Divide by zero already yields remainder = |dividend|, so only the quotient needs overriding
    always_comb begin : result_select
        prod_fix = neg_q ? -acc_step : acc_step;
        quot     = acc_step[NB_WORD-1:0];
        rem      = acc_step[2*NB_WORD-1:NB_WORD];
        if (is_rem)
            result_o = neg_q ? -rem : rem;
        else if (is_div)
            result_o = bzero_q ? '1 : (neg_q ? -quot : quot);
        else if (op_q == MUL)
            result_o = prod_fix[NB_WORD-1:0];
        else
            result_o = prod_fix[2*NB_WORD-1:NB_WORD];
    end

endmodule

// File: rtl/execution_unit_md.sv
// rtl/execution_unit_md.sv - RV32 execute stage: operand forwarding, single-cycle ALU and iterative M-extension unit
module execution_unit_md
    import riscv_defs::*;
#(
    parameter int NB_WORD = 32,
    parameter int NB_CNT  = $clog2(NB_WORD) + 1
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic               i_flush,
    input  control_bus_t       i_control_bus,
    input  logic [NB_WORD-1:0] i_op1,
    input  logic [NB_WORD-1:0] i_op2,
    input  logic [NB_WORD-1:0] i_immediate,
    input  logic [NB_WORD-1:0] i_pc,
    input  logic [1:0]         i_forward_rs1,
    input  logic [1:0]         i_forward_rs2,
    input  logic [NB_WORD-1:0] i_ex_mem_alu_res,
    input  logic [NB_WORD-1:0] i_wb_res,
    output logic               o_busy,
    output logic               o_valid,
    output logic [NB_WORD-1:0] o_result
);
    logic [NB_WORD-1:0] op1, op2, alu_res, md_res;
    logic [NB_WORD-1:0] result_q, result_d;
    logic               valid_q, valid_d;
    logic               accept, alu_accept, md_start, md_busy, md_done;

    always_comb begin : operand_select
        if (i_control_bus.alu_src1)       op1 = i_pc;
        else if (i_forward_rs1 == 2'b10)  op1 = i_ex_mem_alu_res;
        else if (i_forward_rs1 == 2'b01)  op1 = i_wb_res;
        else                              op1 = i_op1;

        if (i_control_bus.alu_src2)       op2 = i_immediate;
        else if (i_forward_rs2 == 2'b10)  op2 = i_ex_mem_alu_res;
        else if (i_forward_rs2 == 2'b01)  op2 = i_wb_res;
        else                              op2 = i_op2;
    end

    // Flush overrides a same-cycle valid; nothing is taken while the M unit is busy
    assign accept     = i_valid && !md_busy && !i_flush;
    assign alu_accept = accept && !i_control_bus.md_en;
    assign md_start   = accept && i_control_bus.md_en;

    alu #(
        .NB_WORD (NB_WORD)
    ) u_alu (
        .a_i           (op1),
        .b_i           (op2),
        .op_i          (i_control_bus.alu_op),
        .arith_logic_i (i_control_bus.arith_logic),
        .result_o      (alu_res)
    );

    md_unit #(
        .NB_WORD (NB_WORD),
        .NB_CNT  (NB_CNT)
    ) u_md_unit (
        .clk_i    (i_clock),
        .reset_i  (i_reset),
        .start_i  (md_start),
        .flush_i  (i_flush),
        .op_i     (i_control_bus.md_op),
        .a_i      (op1),
        .b_i      (op2),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .result_o (md_res)
    );

    always_comb begin : result_mux
        valid_d  = alu_accept || md_done;
        result_d = result_q;
        if (md_done)
            result_d = md_res;
        else if (alu_accept)
            result_d = alu_res;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    assign o_busy   = md_busy;
    assign o_valid  = valid_q;
    assign o_result = result_q;

endmodule

// File: tb/tb_execution_unit_md.sv
// tb/tb_execution_unit_md.sv - self-checking bench: vector table, random ops against a reference model, flush/reset sequences
module tb_execution_unit_md;
    import riscv_defs::*;

    typedef struct {
        control_bus_t ctrl;
        logic [31:0]  op1, op2, imm, pc, exm, wb;
        logic [1:0]   f1, f2;
        logic [31:0]  exp;
    } vec_t;

    logic         i_clock = 1'b0;
    logic         i_reset, i_valid, i_flush;
    control_bus_t i_control_bus;
    logic [31:0]  i_op1, i_op2, i_immediate, i_pc, i_ex_mem_alu_res, i_wb_res;
    logic [1:0]   i_forward_rs1, i_forward_rs2;
    logic         o_busy, o_valid;
    logic [31:0]  o_result;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[16];

    always #5 i_clock = ~i_clock;

    execution_unit_md #(.NB_WORD(32)) dut (
        .i_clock          (i_clock),
        .i_reset          (i_reset),
        .i_valid          (i_valid),
        .i_flush          (i_flush),
        .i_control_bus    (i_control_bus),
        .i_op1            (i_op1),
        .i_op2            (i_op2),
        .i_immediate      (i_immediate),
        .i_pc             (i_pc),
        .i_forward_rs1    (i_forward_rs1),
        .i_forward_rs2    (i_forward_rs2),
        .i_ex_mem_alu_res (i_ex_mem_alu_res),
        .i_wb_res         (i_wb_res),
        .o_busy           (o_busy),
        .o_valid          (o_valid),
        .o_result         (o_result)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic control_bus_t mkc(input logic s1, input logic s2, input alu_op_t op,
                                         input logic arith, input logic md_en, input md_op_t mop);
        control_bus_t c;
        c.alu_src1 = s1;  c.alu_src2 = s2;  c.alu_op = op;
        c.arith_logic = arith;  c.md_en = md_en;  c.md_op = mop;
        return c;
    endfunction

    function automatic vec_t mkv(input control_bus_t c, input logic [31:0] op1, input logic [31:0] op2,
                                 input logic [31:0] imm, input logic [31:0] pc, input logic [1:0] f1,
                                 input logic [1:0] f2, input logic [31:0] exm, input logic [31:0] wb,
                                 input logic [31:0] exp);
        vec_t v;
        v.ctrl = c;  v.op1 = op1;  v.op2 = op2;  v.imm = imm;  v.pc = pc;
        v.f1 = f1;  v.f2 = f2;  v.exm = exm;  v.wb = wb;  v.exp = exp;
        return v;
    endfunction

    function automatic logic [31:0] sel_op(input logic src, input logic [31:0] alt, input logic [1:0] fwd,
                                           input logic [31:0] rf, input logic [31:0] exm, input logic [31:0] wb);
        if (src) return alt;
        if (fwd == 2'b10) return exm;
        if (fwd == 2'b01) return wb;
        return rf;
    endfunction

    function automatic logic [31:0] alu_model(input alu_op_t op, input logic arith, input logic [31:0] a,
                                              input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            ALU_ADD:  return arith ? a - b : a + b;
            ALU_SLL:  return a << sh;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_SR:   return arith ? 32'($signed(a) >>> sh) : a >> sh;
            ALU_OR:   return a | b;
            default:  return a & b;
        endcase
    endfunction

    // Plain 64-bit arithmetic; SV division truncates toward zero and % takes the dividend sign
    function automatic logic [31:0] md_model(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic ovf;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            MUL:     begin p = 64'(sa * sb); return p[31:0];  end
            MULH:    begin p = 64'(sa * sb); return p[63:32]; end
            MULHSU:  begin p = 64'(sa * ub); return p[63:32]; end
            MULHU:   begin p = 64'(ua * ub); return p[63:32]; end
            DIV:     begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = 64'(sa / sb); return p[31:0];
            end
            DIVU:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM:     begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = 64'(sa % sb); return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] model(input vec_t v);
        logic [31:0] a, b;
        a = sel_op(v.ctrl.alu_src1, v.pc, v.f1, v.op1, v.exm, v.wb);
        b = sel_op(v.ctrl.alu_src2, v.imm, v.f2, v.op2, v.exm, v.wb);
        if (v.ctrl.md_en) return md_model(v.ctrl.md_op, a, b);
        return alu_model(v.ctrl.alu_op, v.ctrl.arith_logic, a, b);
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input vec_t v);
        i_control_bus = v.ctrl;  i_op1 = v.op1;  i_op2 = v.op2;  i_immediate = v.imm;  i_pc = v.pc;
        i_forward_rs1 = v.f1;  i_forward_rs2 = v.f2;  i_ex_mem_alu_res = v.exm;  i_wb_res = v.wb;
    endtask

    task automatic scramble();
        i_op1 = $urandom;  i_op2 = $urandom;  i_immediate = $urandom;  i_pc = $urandom;
        i_ex_mem_alu_res = $urandom;  i_wb_res = $urandom;
    endtask

    // Issue one instruction and check result, latency and busy window; k counts cycles after accept
    task automatic run_op(input vec_t v, input string tag);
        int k, busy_cnt;
        @(negedge i_clock);
        drive(v);
        i_valid = 1'b1;
        @(negedge i_clock);
        i_valid = 1'b0;
        scramble();
        if (!v.ctrl.md_en) begin
            check($sformatf("%s alu valid", tag), 32'(o_valid), 32'd1);
            check($sformatf("%s alu result", tag), o_result, v.exp);
        end else begin
            k = 1;
            busy_cnt = 0;
            while (!o_valid && k < 40) begin
                if (o_busy) busy_cnt++;
                @(negedge i_clock);
                k++;
            end
            check($sformatf("%s md latency", tag), 32'(k), 32'd33);
            check($sformatf("%s md result", tag), o_result, v.exp);
            check($sformatf("%s md busy cycles", tag), 32'(busy_cnt), 32'd32);
            check($sformatf("%s md busy at done", tag), 32'(o_busy), 32'd0);
        end
        @(negedge i_clock);
        check($sformatf("%s valid pulse", tag), 32'(o_valid), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        int k, nvalid;

        vecs[0]  = mkv(mkc(0, 0, ALU_ADD, 0, 0, MUL), 5, 3, 0, 0, 2'b10, 2'b00, 7, 0, 32'd10);
        vecs[1]  = mkv(mkc(0, 1, ALU_ADD, 1, 0, MUL), 20, 99, 8, 0, 2'b00, 2'b00, 0, 0, 32'd12);
        vecs[2]  = mkv(mkc(1, 1, ALU_ADD, 0, 0, MUL), 1, 2, 32'h20, 32'h1000, 2'b10, 2'b01, 32'h5555, 9, 32'h1020);
        vecs[3]  = mkv(mkc(0, 0, ALU_SR, 1, 0, MUL), 32'h8000_0000, 32'h99, 0, 0, 2'b00, 2'b01, 0, 4, 32'hF800_0000);
        vecs[4]  = mkv(mkc(0, 0, ALU_SLT, 0, 0, MUL), 32'hFFFF_FFFF, 1, 0, 0, 2'b00, 2'b00, 0, 0, 32'd1);
        vecs[5]  = mkv(mkc(0, 0, ALU_SLTU, 0, 0, MUL), 32'hFFFF_FFFF, 1, 0, 0, 2'b00, 2'b00, 0, 0, 32'd0);
        vecs[6]  = mkv(mkc(0, 0, ALU_ADD, 0, 1, MULH), 32'hFFFF_FFFD, 5, 0, 0, 2'b00, 2'b00, 0, 0, 32'hFFFF_FFFF);
        vecs[7]  = mkv(mkc(0, 0, ALU_ADD, 0, 1, MUL), 32'hFFFF_FFFD, 5, 0, 0, 2'b00, 2'b00, 0, 0, 32'hFFFF_FFF1);
        vecs[8]  = mkv(mkc(0, 0, ALU_ADD, 0, 1, MULHSU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 2'b00, 2'b00, 0, 0, 32'hFFFF_FFFF);
        vecs[9]  = mkv(mkc(0, 0, ALU_ADD, 0, 1, MULHU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 2'b00, 2'b00, 0, 0, 32'hFFFF_FFFE);
        vecs[10] = mkv(mkc(0, 0, ALU_ADD, 0, 1, DIV), 7, 0, 0, 0, 2'b00, 2'b00, 0, 0, 32'hFFFF_FFFF);
        vecs[11] = mkv(mkc(0, 0, ALU_ADD, 0, 1, REM), 7, 0, 0, 0, 2'b00, 2'b00, 0, 0, 32'd7);
        vecs[12] = mkv(mkc(0, 0, ALU_ADD, 0, 1, DIV), 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 2'b00, 2'b00, 0, 0, 32'h8000_0000);
        vecs[13] = mkv(mkc(0, 0, ALU_ADD, 0, 1, REM), 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 2'b00, 2'b00, 0, 0, 32'd0);
        vecs[14] = mkv(mkc(0, 0, ALU_ADD, 0, 1, REM), 32'hFFFF_FFF9, 2, 0, 0, 2'b00, 2'b00, 0, 0, 32'hFFFF_FFFF);
        vecs[15] = mkv(mkc(0, 0, ALU_ADD, 0, 1, DIV), 1, 5, 0, 0, 2'b10, 2'b01, 100, 7, 32'd14);

        i_reset = 1'b1;  i_valid = 1'b0;  i_flush = 1'b0;
        drive(vecs[0]);
        repeat (3) @(negedge i_clock);
        check("reset busy", 32'(o_busy), 32'd0);
        check("reset valid", 32'(o_valid), 32'd0);
        check("reset result", o_result, 32'd0);
        i_reset = 1'b0;

        for (int i = 0; i < 16; i++)
            run_op(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            v.ctrl = mkc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), alu_op_t'($urandom_range(0, 7)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), md_op_t'($urandom_range(0, 7)));
            v.op1 = rnd_word();  v.op2 = rnd_word();  v.imm = rnd_word();  v.pc = rnd_word();
            v.exm = rnd_word();  v.wb = rnd_word();
            v.f1 = 2'($urandom_range(0, 3));  v.f2 = 2'($urandom_range(0, 3));
            v.exp = model(v);
            run_op(v, $sformatf("rnd%0d", i));
        end

        // DIVU flushed at RUN cycle 10, then a normal ADD
        @(negedge i_clock);
        drive(mkv(mkc(0, 0, ALU_ADD, 0, 1, DIVU), 1000, 3, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        i_valid = 1'b1;
        @(negedge i_clock);
        i_valid = 1'b0;
        repeat (9) @(negedge i_clock);
        check("flush busy before", 32'(o_busy), 32'd1);
        i_flush = 1'b1;
        @(negedge i_clock);
        i_flush = 1'b0;
        check("flush busy after", 32'(o_busy), 32'd0);
        nvalid = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_valid) nvalid++;
            @(negedge i_clock);
        end
        check("flush no valid", 32'(nvalid), 32'd0);
        run_op(mkv(mkc(0, 0, ALU_ADD, 0, 0, MUL), 40, 2, 0, 0, 2'b00, 2'b00, 0, 0, 32'd42), "post flush add");

        // Flush together with a valid ALU op in IDLE: nothing accepted
        @(negedge i_clock);
        drive(mkv(mkc(0, 0, ALU_ADD, 0, 0, MUL), 1, 2, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        i_valid = 1'b1;
        i_flush = 1'b1;
        @(negedge i_clock);
        i_valid = 1'b0;
        i_flush = 1'b0;
        check("idle flush valid", 32'(o_valid), 32'd0);
        check("idle flush result", o_result, 32'd42);

        // ADD held on i_valid during a MULHU must wait until busy falls
        @(negedge i_clock);
        drive(mkv(mkc(0, 0, ALU_ADD, 0, 1, MULHU), 32'hFFFF_FFFF, 2, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        i_valid = 1'b1;
        @(negedge i_clock);
        drive(mkv(mkc(0, 0, ALU_ADD, 0, 0, MUL), 11, 22, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        k = 1;
        while (!o_valid && k < 40) begin
            @(negedge i_clock);
            k++;
        end
        check("hold md latency", 32'(k), 32'd33);
        check("hold md result", o_result, 32'd1);
        @(negedge i_clock);
        i_valid = 1'b0;
        check("hold add valid", 32'(o_valid), 32'd1);
        check("hold add result", o_result, 32'd33);
        @(negedge i_clock);

        // Reset in the middle of a multiply, then MUL 6x7
        drive(mkv(mkc(0, 0, ALU_ADD, 0, 1, MUL), 123, 456, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        i_valid = 1'b1;
        @(negedge i_clock);
        i_valid = 1'b0;
        repeat (4) @(negedge i_clock);
        i_reset = 1'b1;
        @(negedge i_clock);
        i_reset = 1'b0;
        check("midrun reset busy", 32'(o_busy), 32'd0);
        check("midrun reset valid", 32'(o_valid), 32'd0);
        check("midrun reset result", o_result, 32'd0);
        nvalid = 0;
        for (int i = 0; i < 35; i++) begin
            if (o_valid || o_busy) nvalid++;
            @(negedge i_clock);
        end
        check("midrun reset quiet", 32'(nvalid), 32'd0);
        run_op(mkv(mkc(0, 0, ALU_ADD, 0, 1, MUL), 6, 7, 0, 0, 2'b00, 2'b00, 0, 0, 32'd42), "post reset mul");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
